// File: rtl/rom_burst_reader.sv
// rom_burst_reader: burst address sequencer and read-data buffer for a registered-address ROM.
//
// On an accepted start request it issues ascending ROM addresses (wrapping modulo 2**ADDR_W),
// captures each ROM word the cycle after its address issues, and presents the words in address
// order as a valid/ready stream through a small first-word-fall-through FIFO. Issue is throttled
// by buffer credits so that no word is lost when the consumer stalls.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                burst request, sampled only while idle
//   base_addr, burst_len first address and word count of the burst
//   busy                 high from accepted start until done
//   done                 one-cycle pulse after the last word of the burst is consumed
//   rom_en, rom_addr     registered ROM enable/address, one address per enabled cycle
//   rom_data             ROM read data, valid the cycle after rom_en
//   out_data, out_valid  head word of the buffer and buffer non-empty
//   out_ready            consumer accepts when out_valid & out_ready

module rom_burst_reader #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned LEN_W      = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;       // next address to issue
  logic [LEN_W-1:0]  remaining_q;  // addresses still to issue
  logic              inflight_q;   // ROM word arrives on rom_data this cycle

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  logic push, pop, credit_ok, last_pop;

  assign push      = inflight_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // rom_en is registered, so the decision made at this edge governs the next cycle's issue.
  // Occupancy after this edge plus the word currently being read must leave a free slot.
  assign credit_ok = ({1'b0, count_d} + {{CntW{1'b0}}, rom_en}) < (CntW + 1)'(FIFO_DEPTH);

  // The final word leaves the buffer with nothing still coming from the ROM.
  assign last_pop = (state_q == StDrain) && !rom_en && !inflight_q &&
                    (count_q == CntW'(1)) && pop;

  // Output buffer and ROM capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rom_en;
      if (push) begin
        mem_q[wr_ptr_q] <= rom_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  // Burst control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      rom_en <= 1'b0;
      done   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (burst_len != '0) begin
              // First address issues in the cycle right after acceptance.
              rom_en      <= 1'b1;
              rom_addr    <= base_addr;
              addr_q      <= base_addr + ADDR_W'(1);
              remaining_q <= burst_len - LEN_W'(1);
              busy        <= 1'b1;
              state_q     <= (burst_len == LEN_W'(1)) ? StDrain : StIssue;
            end else begin
              done <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (credit_ok) begin
            rom_en      <= 1'b1;
            rom_addr    <= addr_q;
            addr_q      <= addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (last_pop) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: registered-address ROM model, address and data
// scoreboards filled when a burst is requested and drained as the DUT issues and delivers.

module tb_rom_burst_reader;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              busy, done, rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  rom_burst_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .burst_len(burst_len),
    .busy     (busy),
    .done     (done),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // ROM model: address registered on rom_en, data = addr[3:0] ^ 5.
  logic [ADDR_W-1:0] rom_q = '0;
  always @(posedge clk) if (rom_en) rom_q <= rom_addr;
  assign rom_data = rom_q[3:0] ^ 4'h5;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  int issued = 0, consumed = 0, done_cnt = 0, rom_en_cnt = 0;
  int cyc = 0, hs_first = -1, hs_last = -1;
  bit rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done) done_cnt++;
      if (rom_en) begin
        rom_en_cnt++;
        issued++;
        check_eq("credit_overrun", 32'(issued - consumed > int'(DEPTH)), 32'd0);
        if (exp_addr_q.size() == 0) check_eq("extra_issue", 32'(rom_en), 32'd0);
        else check_eq("rom_addr", 32'(rom_addr), 32'(exp_addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        consumed++;
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
        if (exp_data_q.size() == 0) check_eq("extra_word", 32'(out_valid), 32'd0);
        else check_eq("out_data", 32'(out_data), 32'(exp_data_q.pop_front()));
      end
    end
  end

  task automatic run_burst(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
    logic [ADDR_W-1:0] a;
    @(posedge clk); #1;
    base_addr = b;
    burst_len = l;
    start     = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      a = b + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(a[3:0] ^ 4'h5);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = ~b;       // later changes must not affect the burst
    burst_len = ~l;
  endtask

  task automatic wait_done(input string tag);
    int  prev = done_cnt;
    bit  seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_cnt != prev) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_once"}, 32'(done_cnt - prev), 32'd1);
    check_eq({tag, "_busy_low"}, 32'(busy), 32'd0);
    check_eq({tag, "_sb_empty"}, 32'(exp_data_q.size() + exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    int c0, d0;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    burst_len = '0;
    out_ready = 1'b1;
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rom_en", 32'(rom_en), 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1) basic burst with latency and throughput checks
    hs_first = -1;
    run_burst(5'd3, 6'd4);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_first_rom_en", 32'(rom_en), 32'd1);
    @(posedge clk); #1;
    check_eq("t1_valid_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("t1_first_valid", 32'(out_valid), 32'd1);
    wait_done("t1");
    check_eq("t1_back_to_back", 32'(hs_last - hs_first), 32'd3);

    // 2) address wrap
    run_burst(5'd30, 6'd4);
    wait_done("t2");

    // 3) stalled consumer: issue stops at the credit limit
    @(posedge clk); #1;
    out_ready = 1'b0;
    c0 = rom_en_cnt;
    run_burst(5'd0, 6'd8);
    repeat (20) @(negedge clk);
    check_eq("t3_stall_issues", 32'(rom_en_cnt - c0), 32'(DEPTH));
    check_eq("t3_stall_full", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("t3");

    // 4) random back-pressure over a long burst
    rand_ready = 1'b1;
    run_burst(5'd10, 6'd40);
    wait_done("t4");
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // 5) zero-length burst, then start while busy
    c0 = rom_en_cnt;
    d0 = done_cnt;
    run_burst(5'd7, 6'd0);
    check_eq("t5_busy_zero", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("t5_no_issue", 32'(rom_en_cnt - c0), 32'd0);
    check_eq("t5_done_once", 32'(done_cnt - d0), 32'd1);
    check_eq("t5_busy_after", 32'(busy), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_burst(5'd1, 6'd3);
    @(posedge clk); #1;
    base_addr = 5'd20;
    burst_len = 6'd5;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b1;
    wait_done("t5");

    // 6) reset mid-burst, then a fresh burst
    c0 = consumed;
    run_burst(5'd0, 6'd10);
    for (int i = 0; i < 100 && consumed - c0 < 3; i++) @(negedge clk);
    check_eq("t6_three_words", 32'(consumed - c0), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_rom_en", 32'(rom_en), 32'd0);
    check_eq("t6_rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_data", 32'(out_data), 32'd0);
    check_eq("t6_rst_done", 32'(done), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    issued = consumed;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_burst(5'd5, 6'd2);
    wait_done("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
